// File: rtl/interrupt_sequencer.sv
// Seven-cycle BRK/IRQ/NMI/RESET entry sequencer: pushes PCH/PCL/PSR to the stack page,
// then fetches the selected vector into PCL/PCH while holding control away from the decoder.
module interrupt_sequencer #(
    parameter logic [7:0] VEC_NMI    = 8'hFA,
    parameter logic [7:0] VEC_RES    = 8'hFC,
    parameter logic [7:0] VEC_IRQ    = 8'hFE,
    parameter logic [7:0] STACK_PAGE = 8'h01
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SYNC,
    input  logic       BRK_REQ,
    input  logic       IRQ_N,
    input  logic       NMI_N,
    input  logic       I_FLAG,
    output logic       BUSY,
    output logic       RW,
    output logic [7:0] ADH_OUT,
    output logic [7:0] ADL_VEC,
    output logic       S_ADL_BUS_ENABLE,
    output logic       S_DEC,
    output logic       PCH_DB_ENABLE,
    output logic       PCL_DB_ENABLE,
    output logic       PSR_BUS_ENABLE,
    output logic       B_OUT,
    output logic       PCL_LOAD_DB,
    output logic       PCH_LOAD_DB,
    output logic       I_SET,
    output logic       NMI_ACK,
    output logic [2:0] DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_T6   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        K_RESET = 2'd0,
        K_BRK   = 2'd1,
        K_IRQ   = 2'd2,
        K_NMI   = 2'd3
    } kind_t;

    state_t state_q, state_d;
    kind_t  kind_q, kind_d;
    logic   take_nmi_q, take_nmi_d;
    logic   nmi_q;
    logic   nmi_pend_q, nmi_pend_d;
    logic   nmi_fall;
    logic   nmi_consume;
    logic   stack_cyc;
    logic   push_en;
    logic [7:0] vec_base;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_T1;
            kind_q     <= K_RESET;
            take_nmi_q <= 1'b0;
            nmi_q      <= 1'b1;
            nmi_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            take_nmi_q <= take_nmi_d;
            nmi_q      <= NMI_N;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    // A new falling edge in the consuming cycle survives the clear, so it is taken later.
    assign nmi_fall    = nmi_q & ~NMI_N;
    assign nmi_consume = (state_q == S_T5) && take_nmi_q;
    assign nmi_pend_d  = (nmi_pend_q & ~nmi_consume) | nmi_fall;

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        take_nmi_d = take_nmi_q;
        unique case (state_q)
            S_IDLE: begin
                if (SYNC) begin
                    take_nmi_d = 1'b0;
                    if (nmi_pend_q) begin
                        state_d = S_T1;
                        kind_d  = K_NMI;
                    end else if (!IRQ_N && !I_FLAG) begin
                        state_d = S_T1;
                        kind_d  = K_IRQ;
                    end else if (BRK_REQ) begin
                        state_d = S_T1;
                        kind_d  = K_BRK;
                    end
                end
            end
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: state_d = S_T4;
            S_T4: begin
                state_d    = S_T5;
                // Vector is latched here; a pending NMI hijacks an IRQ/BRK sequence.
                take_nmi_d = (kind_q != K_RESET) && (nmi_pend_q || nmi_fall);
            end
            S_T5: state_d = S_T6;
            S_T6: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign stack_cyc = (state_q == S_T2) || (state_q == S_T3) || (state_q == S_T4);
    assign push_en   = kind_q != K_RESET;
    assign vec_base  = (kind_q == K_RESET) ? VEC_RES : (take_nmi_q ? VEC_NMI : VEC_IRQ);

    always_comb begin
        BUSY             = (state_q != S_IDLE);
        RW               = 1'b1;
        ADH_OUT          = 8'h00;
        ADL_VEC          = 8'h00;
        S_ADL_BUS_ENABLE = 1'b0;
        S_DEC            = 1'b0;
        PCH_DB_ENABLE    = 1'b0;
        PCL_DB_ENABLE    = 1'b0;
        PSR_BUS_ENABLE   = 1'b0;
        B_OUT            = (state_q != S_IDLE) && (kind_q == K_BRK);
        PCL_LOAD_DB      = 1'b0;
        PCH_LOAD_DB      = 1'b0;
        I_SET            = 1'b0;
        NMI_ACK          = 1'b0;
        if (stack_cyc) begin
            ADH_OUT          = STACK_PAGE;
            S_ADL_BUS_ENABLE = 1'b1;
            S_DEC            = 1'b1;
            RW               = ~push_en;
            PCH_DB_ENABLE    = push_en && (state_q == S_T2);
            PCL_DB_ENABLE    = push_en && (state_q == S_T3);
            PSR_BUS_ENABLE   = push_en && (state_q == S_T4);
        end
        if (state_q == S_T5) begin
            ADH_OUT     = 8'hFF;
            ADL_VEC     = vec_base;
            PCL_LOAD_DB = 1'b1;
            I_SET       = 1'b1;
            NMI_ACK     = take_nmi_q;
        end
        if (state_q == S_T6) begin
            ADH_OUT     = 8'hFF;
            ADL_VEC     = vec_base + 8'd1;
            PCH_LOAD_DB = 1'b1;
        end
        // Reset takes the datapath immediately, before the synchronous state update.
        if (RST) begin
            BUSY             = 1'b1;
            RW               = 1'b1;
            ADH_OUT          = 8'h00;
            ADL_VEC          = 8'h00;
            S_ADL_BUS_ENABLE = 1'b0;
            S_DEC            = 1'b0;
            PCH_DB_ENABLE    = 1'b0;
            PCL_DB_ENABLE    = 1'b0;
            PSR_BUS_ENABLE   = 1'b0;
            B_OUT            = 1'b0;
            PCL_LOAD_DB      = 1'b0;
            PCH_LOAD_DB      = 1'b0;
            I_SET            = 1'b0;
            NMI_ACK          = 1'b0;
        end
    end

    assign DBG_STATE = state_q;

endmodule
